// File: rtl/mdu_sequencer_if.sv
// Handshake/result bundle between the decoder/pipeline and the multiply/divide unit.
//   master : decoder side, drives start/op/a/b/rd_req (and MTHI/MTLO writes)
//   slave  : MDU side, drives busy/stall/done/hi/lo
// Optional MTHI/MTLO write port is present when MDU_MTHILO_EN is defined.
interface mdu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_MTHILO_EN
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, op, a, b, rd_req, wr_hi, wr_lo, wdata,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_req, wr_hi, wr_lo, wdata,
    output busy, stall, done, hi, lo
  );
`else
  modport master (
    output start, op, a, b, rd_req,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_req,
    output busy, stall, done, hi, lo
  );
`endif
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with sequencer, HI/LO registers and stall logic.
// One bit per cycle: shift-add multiply, restoring divide; W run cycles plus a
// fixup cycle that applies signs / divide-by-zero results and writes HI/LO.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : mdu_sequencer_if.slave
//            start/op/a/b launch (op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//            rd_req MFHI/MFLO in decode; busy, stall (combinational), done pulse
//            hi/lo result registers
// Optional: MDU_MTHILO_EN adds wr_hi/wr_lo/wdata (MTHI/MTLO) on the interface.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mdu_sequencer_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic               div0_q;
  logic [WIDTH-1:0]   orig_a_q;
  logic [WIDTH-1:0]   mag_a_q;   // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   mag_b_q;   // multiplier (shifts right), or divisor
  logic [2*WIDTH-1:0] acc_q;     // product, or remainder in the upper half
  logic [CW-1:0]      cnt_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               busy;
  logic               start_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy      = (state_q != ST_IDLE);
  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

`ifdef MDU_MTHILO_EN
  assign bus.stall = (bus.rd_req | bus.start | bus.wr_hi | bus.wr_lo) & busy;
`else
  assign bus.stall = (bus.rd_req | bus.start) & busy;
`endif

  // Operand magnitudes at launch; the most negative value keeps its bit pattern
  // and is then read as an unsigned magnitude.
  assign start_signed = ~bus.op[0];
  assign neg_a        = start_signed & bus.a[WIDTH-1];
  assign neg_b        = start_signed & bus.b[WIDTH-1];
  assign abs_a        = neg_a ? (WIDTH'(0) - bus.a) : bus.a;
  assign abs_b        = neg_b ? (WIDTH'(0) - bus.b) : bus.b;

  // Shift-add step: W+1-bit add into the upper half, carry shifts back in.
  assign acc_hi  = acc_q[2*WIDTH-1:WIDTH];
  assign mul_sum = {1'b0, acc_hi} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);

  // Restoring divide step on the shifted remainder:dividend pair.
  assign div_shift = {acc_hi, mag_a_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_ge    = (div_shift >= {1'b0, mag_b_q});
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  // Sign fixup; sa_q/sb_q are already zero for unsigned ops.
  assign prod_fix = (sa_q ^ sb_q) ? ((2*WIDTH)'(0) - acc_q) : acc_q;
  assign quot_fix = (sa_q ^ sb_q) ? (WIDTH'(0) - mag_a_q) : mag_a_q;
  assign rem_fix  = sa_q ? (WIDTH'(0) - acc_hi) : acc_hi;

  // Sequencer, datapath registers and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      orig_a_q <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            sa_q     <= neg_a;
            sb_q     <= neg_b;
            div0_q   <= (bus.b == '0);
            orig_a_q <= bus.a;
            mag_a_q  <= abs_a;
            mag_b_q  <= abs_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
`ifdef MDU_MTHILO_EN
          if (bus.wr_hi) hi_q <= bus.wdata;
          if (bus.wr_lo) lo_q <= bus.wdata;
`endif
        end

        ST_RUN: begin
          if (op_q[1]) begin
            acc_q   <= {div_rem, WIDTH'(0)};
            mag_a_q <= {mag_a_q[WIDTH-2:0], div_ge};
          end else begin
            acc_q   <= {mul_sum, acc_q[WIDTH-1:1]};
            mag_b_q <= {1'b0, mag_b_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIXUP;
        end

        ST_FIXUP: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            hi_q <= orig_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against an arithmetic model.
module tb_mdu_sequencer;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  mdu_sequencer_if #(.WIDTH(W)) bus ();

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Launch one op, optionally hold rd_req from cycle rd_from and pulse a second
  // start at cycle s2_at, then check timing, stall and results.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int rd_from, input int s2_at, input bit rd_with_start,
                        output logic [31:0] got_hi, output logic [31:0] got_lo);
    logic [63:0] exp;
    int cyc, busy_cnt;
    bit seen;
    exp = ref_model(op, a, b);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1; bus.rd_req = rd_with_start;
    #1;
    check("stall_idle_start", 64'(bus.stall), 64'd0);
    if (rd_with_start) begin
      check("hi_old_read", 64'(bus.hi), 64'(last_hi));
      check("lo_old_read", 64'(bus.lo), 64'(last_lo));
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rd_req = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    got_hi = '0; got_lo = '0;
    while (!seen && cyc <= 40) begin
      bus.rd_req = (rd_from >= 0 && cyc >= rd_from);
      bus.start  = (cyc == s2_at);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        got_hi = bus.hi; got_lo = bus.lo;
        check("latency", 64'(cyc), 64'(W + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        if (bus.rd_req) check("stall_in_done", 64'(bus.stall), 64'd0);
        check("hi", 64'(bus.hi), 64'(exp[63:32]));
        check("lo", 64'(bus.lo), 64'(exp[31:0]));
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.rd_req || bus.start) check("stall_busy", 64'(bus.stall), 64'd1);
        if (cyc == 16) begin
          check("hi_hold", 64'(bus.hi), 64'(last_hi));
          check("lo_hold", 64'(bus.lo), 64'(last_lo));
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    bus.rd_req = 1'b0; bus.start = 1'b0;
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    @(posedge clk); #1;
    check("done_pulse_end", 64'(bus.done), 64'd0);
    check("hi_after", 64'(bus.hi), 64'(last_hi));
  endtask

  initial begin
    logic [31:0] h, l;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int rd_from;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.rd_req = 1'b0;
`ifdef MDU_MTHILO_EN
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
`endif
    last_hi = '0; last_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall_rd_idle", 64'(bus.stall), 64'd0);
    bus.rd_req = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived results.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0, h, l);
    check("multu_ff_hi", 64'(h), 64'hFFFF_FFFE);
    check("multu_ff_lo", 64'(l), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1, 1'b0, h, l);
    check("mult_m3x5_hi", 64'(h), 64'hFFFF_FFFF);
    check("mult_m3x5_lo", 64'(l), 64'hFFFF_FFF1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b1, h, l);
    check("div_m7d2_lo", 64'(l), 64'hFFFF_FFFD);
    check("div_m7d2_hi", 64'(h), 64'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_1234, 32'd0, -1, -1, 1'b0, h, l);
    check("divu_by0_lo", 64'(l), 64'hFFFF_FFFF);
    check("divu_by0_hi", 64'(h), 64'h0000_1234);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, h, l);
    check("div_ovf_lo", 64'(l), 64'h8000_0000);
    check("div_ovf_hi", 64'(h), 64'h0000_0000);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, -1, -1, 1'b0, h, l);
    check("div_by0_neg_hi", 64'(h), 64'hFFFF_FF00);
    run_op(2'b01, 32'd6, 32'd7, 2, 5, 1'b0, h, l);
    check("multu_6x7_lo", 64'(l), 64'd42);

    // Reset part-way through a DIVU abandons it and clears HI/LO.
    bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    last_hi = '0; last_lo = '0;
    run_op(2'b11, 32'd100, 32'd7, -1, -1, 1'b0, h, l);
    check("divu_100d7_lo", 64'(l), 64'd14);
    check("divu_100d7_hi", 64'(h), 64'd2);

    // Randomized ops with occasional corner operands and overlapping reads.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      rd_from = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 32)) : -1;
      run_op(rop, ra, rb, rd_from, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), h, l);
    end

`ifdef MDU_MTHILO_EN
    bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    #1;
    check("mthi_idle_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.wr_hi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    check("mthi_lo_kept", 64'(bus.lo), 64'(last_lo));
    last_hi = 32'hDEAD_BEEF;
    bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.wr_lo = 1'b1; bus.wdata = 32'h1111_2222;
    #1;
    check("mtlo_busy_stall", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    check("mtlo_busy_lo_kept", 64'(bus.lo), 64'(last_lo));
    bus.wr_lo = 1'b0;
    begin
      int k;
      k = 0;
      while (!bus.done && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      check("mtlo_done_seen", 64'(bus.done), 64'd1);
      check("mtlo_done_lo", 64'(bus.lo), 64'd42);
    end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("mthilo_both_hi", 64'(bus.hi), 64'h0BAD_F00D);
    check("mthilo_both_lo", 64'(bus.lo), 64'h0BAD_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
